// File: rtl/queue_tx_framer_if.sv
// Queue-side and MAC-side signal bundle for queue_tx_framer.
// master = framer side, slave = queue/MAC side.
interface queue_tx_framer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH:0]   q_dout;
  logic                  q_empty;
  logic                  q_rd_en;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tlast;
  logic                  m_tready;

  // Stream handshake: a beat transfers on each clk edge where m_tvalid & m_tready;
  // while m_tvalid & !m_tready the source holds m_tdata/m_tlast stable and may not drop m_tvalid.
  modport master (
    input  q_dout, q_empty, m_tready,
    output q_rd_en, m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    output q_dout, q_empty, m_tready,
    input  q_rd_en, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/queue_tx_framer.sv
// Pops {last,data} words from a FWFT byte queue onto a registered stream, enforcing an inter-frame gap.
// Optional minimum-length zero padding is enabled by defining QUEUE_TX_PAD_EN.
module queue_tx_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int IFG_CYCLES = 12,
  parameter int MIN_FRAME  = 60,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  queue_tx_framer_if.master    bus,
  output logic                 busy,
  output logic                 underrun,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [1:0]           fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
`ifdef QUEUE_TX_PAD_EN
    ,
    PAD  = 2'd3
`endif
  } state_t;

  localparam logic [7:0] GAP_LAST = 8'(IFG_CYCLES - 1);
`ifdef QUEUE_TX_PAD_EN
  localparam logic [CNT_WIDTH-1:0] MIN_CNT = CNT_WIDTH'(MIN_FRAME);
`endif

  state_t                 state, state_nxt;
  logic [DATA_WIDTH-1:0]  tdata_r, load_data;
  logic                   tvalid_r, tlast_r, underrun_r, load_last;
  logic [CNT_WIDTH-1:0]   byte_cnt, byte_cnt_nxt, byte_cnt_inc, pop_cnt, frame_cnt_r;
  logic [7:0]             gap_cnt;
  logic                   ofree, word_last, gap_done, start, pop, load, handshake_last;

  assign ofree          = !tvalid_r | bus.m_tready;
  assign word_last      = bus.q_dout[DATA_WIDTH];
  assign handshake_last = tvalid_r & bus.m_tready & tlast_r;
  // The final gap cycle doubles as the IDLE decision so the gap is exactly IFG_CYCLES long.
  assign gap_done       = (state == GAP) & !tvalid_r & (gap_cnt == GAP_LAST);
  assign start          = rst_n & ofree & en & !bus.q_empty & ((state == IDLE) | gap_done);
  assign pop            = start | ((state == XFER) & ofree & !bus.q_empty);
  assign byte_cnt_inc   = (&byte_cnt) ? byte_cnt : byte_cnt + 1'b1;
  assign pop_cnt        = start ? CNT_WIDTH'(1) : byte_cnt_inc;

  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    load_data    = bus.q_dout[DATA_WIDTH-1:0];
    load_last    = word_last;
    byte_cnt_nxt = byte_cnt;
    if (pop) begin
      load         = 1'b1;
      byte_cnt_nxt = pop_cnt;
    end
    case (state)
      IDLE, GAP: begin
        if (start)         state_nxt = word_last ? GAP : XFER;
        else if (gap_done) state_nxt = IDLE;
      end
      XFER: begin
        if (pop && word_last) state_nxt = GAP;
      end
`ifdef QUEUE_TX_PAD_EN
      PAD: begin
        if (ofree) begin
          load         = 1'b1;
          load_data    = '0;
          byte_cnt_nxt = byte_cnt_inc;
          load_last    = (byte_cnt_inc == MIN_CNT);
          if (load_last) state_nxt = GAP;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
`ifdef QUEUE_TX_PAD_EN
    // A short frame's real last word goes out as an ordinary beat; PAD supplies the tlast.
    if (pop && word_last && (pop_cnt < MIN_CNT)) begin
      load_last = 1'b0;
      state_nxt = PAD;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata_r     <= '0;
      tvalid_r    <= 1'b0;
      tlast_r     <= 1'b0;
      underrun_r  <= 1'b0;
      frame_cnt_r <= '0;
      byte_cnt    <= '0;
      gap_cnt     <= '0;
    end else begin
      byte_cnt <= byte_cnt_nxt;
      if (load) begin
        tdata_r  <= load_data;
        tvalid_r <= 1'b1;
        tlast_r  <= load_last;
      end else if (ofree) begin
        tvalid_r <= 1'b0;
      end
      underrun_r <= (state == XFER) & ofree & bus.q_empty;
      // gap_cnt only advances once the tlast beat has left the output register.
      if (handshake_last) begin
        gap_cnt     <= '0;
        frame_cnt_r <= frame_cnt_r + 1'b1;
      end else if ((state == GAP) && !tvalid_r) begin
        gap_cnt <= gap_cnt + 8'd1;
      end
    end
  end

  assign bus.q_rd_en  = pop;
  assign bus.m_tdata  = tdata_r;
  assign bus.m_tvalid = tvalid_r;
  assign bus.m_tlast  = tlast_r;
  assign busy         = (state != IDLE);
  assign underrun     = underrun_r;
  assign frame_cnt    = frame_cnt_r;
  assign fsm_state    = state;

endmodule
